// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: data width plus default FIFO depth and idle-timeout values
// used by the RX/TX stages and by uart_rx_fifo.
package uart_rx_fifo_pkg;
  localparam int          UART_DATA_W     = 8;
  localparam int          FIFO_DEPTH_DEF  = 16;
  localparam int          FIFO_ADDR_W_DEF = 4;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd1000;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for uart_rx_fifo: DEPTH x UART_DATA_W array, synchronous write,
// asynchronous (show-ahead) read. Contents are never reset.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  output logic [UART_DATA_W-1:0] o_rd_data
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO: one push per rising edge of rxAvailIn, valid/ready pop, sticky
// overflow/error flags. Optional idle timeout enabled by UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int          DEPTH       = FIFO_DEPTH_DEF,
  parameter int          ADDR_W      = FIFO_ADDR_W_DEF,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rxDataIn,
  input  logic                   rxAvailIn,
  input  logic                   rxErrorIn,
  output logic [UART_DATA_W-1:0] dataOut,
  output logic                   validOut,
  input  logic                   readyIn,
  output logic [ADDR_W:0]        countOut,
  output logic                   overflowOut,
  output logic                   errorOut,
  input  logic                   clearFlagsIn,
  output logic                   timeoutOut
);

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            r_avail_d;
  logic            r_overflow;
  logic            r_error;

  logic w_push_req;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;
  logic w_err_set;

  // Edge-detect the RX level so a byte held across the RX idle state is taken once.
  assign w_push_req = rxAvailIn & ~r_avail_d;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_pop      = ~w_empty & readyIn;
  assign w_push     = w_push_req & ~rxErrorIn & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & ~rxErrorIn & w_full & ~w_pop;
  assign w_err_set  = w_push_req & rxErrorIn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_avail_d  <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_avail_d <= rxAvailIn;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // A new event in the same cycle as a clear keeps the flag set.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clearFlagsIn) begin
        r_overflow <= 1'b0;
      end
      if (w_err_set) begin
        r_error <= 1'b1;
      end else if (clearFlagsIn) begin
        r_error <= 1'b0;
      end
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (rxDataIn),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (dataOut)
  );

  assign validOut    = ~w_empty;
  assign countOut    = r_wr_ptr - r_rd_ptr;
  assign overflowOut = r_overflow;
  assign errorOut    = r_error;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (w_push | w_pop | w_empty) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != TIMEOUT_CYC) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign timeoutOut = (r_idle_cnt == TIMEOUT_CYC) & validOut;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign timeoutOut       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a per-cycle vector table plus hand-written
// sequences for fill/overflow, full push+pop, reset mid-transfer and the idle timeout.
module tb_uart_rx_fifo;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 4;
  localparam logic [15:0] TMO    = 16'd20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxDataIn;
  logic       rxAvailIn;
  logic       rxErrorIn;
  logic [7:0] dataOut;
  logic       validOut;
  logic       readyIn;
  logic [4:0] countOut;
  logic       overflowOut;
  logic       errorOut;
  logic       clearFlagsIn;
  logic       timeoutOut;

  int n_pass  = 0;
  int n_total = 0;

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxDataIn     (rxDataIn),
    .rxAvailIn    (rxAvailIn),
    .rxErrorIn    (rxErrorIn),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .readyIn      (readyIn),
    .countOut     (countOut),
    .overflowOut  (overflowOut),
    .errorOut     (errorOut),
    .clearFlagsIn (clearFlagsIn),
    .timeoutOut   (timeoutOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       avail;
    logic       err;
    logic       ready;
    logic       clr;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e);
    rxDataIn  = d;
    rxErrorIn = e;
    rxAvailIn = 1'b1;
    tick();
    rxAvailIn = 1'b0;
    rxErrorIn = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_b;
    logic       exp_t;

    //             data   av    er    rdy   clr   cnt    vld   head   ovf   err
    vecs[0]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[1]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[2]  = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[5]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h44, 1'b0, 1'b0};
    vecs[6]  = '{8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h44, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 8'h44, 1'b0, 1'b1};
    vecs[8]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 8'h44, 1'b0, 1'b0};
    vecs[9]  = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 8'h44, 1'b0, 1'b1};
    vecs[10] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h44, 1'b0, 1'b1};
    vecs[11] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h66, 1'b0, 1'b1};
    vecs[13] = '{8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[14] = '{8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    reset = 1'b1; rxDataIn = 8'h00; rxAvailIn = 1'b0; rxErrorIn = 1'b0;
    readyIn = 1'b0; clearFlagsIn = 1'b0;
    tick(); tick();
    check("rst_count", 32'(countOut), 32'd0);
    check("rst_valid", 32'(validOut), 32'd0);
    check("rst_ovf", 32'(overflowOut), 32'd0);
    check("rst_err", 32'(errorOut), 32'd0);
    check("rst_tmo", 32'(timeoutOut), 32'd0);
    reset = 1'b0;
    tick();

    // Level held for 50 cycles must produce a single push.
    rxDataIn = 8'hA5; rxAvailIn = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("hold_count", 32'(countOut), 32'd1);
    check("hold_valid", 32'(validOut), 32'd1);
    check("hold_data", 32'(dataOut), 32'hA5);
    rxAvailIn = 1'b0; tick();
    readyIn = 1'b1; tick();
    readyIn = 1'b0;
    check("hold_drain", 32'(countOut), 32'd0);

    for (int i = 0; i < 15; i++) begin
      rxDataIn = vecs[i].data; rxAvailIn = vecs[i].avail; rxErrorIn = vecs[i].err;
      readyIn = vecs[i].ready; clearFlagsIn = vecs[i].clr;
      tick();
      $display("vec %0d: count=%0d valid=%0d data=%0h ovf=%0d err=%0d", i,
               countOut, validOut, dataOut, overflowOut, errorOut);
      check($sformatf("vec%0d_count", i), 32'(countOut), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_valid", i), 32'(validOut), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_ovf", i), 32'(overflowOut), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_err", i), 32'(errorOut), 32'(vecs[i].e_err));
      if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), 32'(dataOut), 32'(vecs[i].e_data));
    end
    rxAvailIn = 1'b0; rxErrorIn = 1'b0; readyIn = 1'b0; clearFlagsIn = 1'b0;
    tick();

    // Fill to 16, then a 17th byte must be dropped with overflow.
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    check("fill_count", 32'(countOut), 32'd16);
    check("fill_ovf", 32'(overflowOut), 32'd0);
    push_byte(8'hFF, 1'b0);
    check("ovf_count", 32'(countOut), 32'd16);
    check("ovf_flag", 32'(overflowOut), 32'd1);
    clearFlagsIn = 1'b1; tick(); clearFlagsIn = 1'b0;
    check("ovf_clear", 32'(overflowOut), 32'd0);

    // Full FIFO: push coinciding with pop is accepted.
    rxDataIn = 8'hAA; rxAvailIn = 1'b1; readyIn = 1'b1;
    tick();
    rxAvailIn = 1'b0; readyIn = 1'b0;
    check("fullpp_count", 32'(countOut), 32'd16);
    check("fullpp_ovf", 32'(overflowOut), 32'd0);
    tick();
    readyIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'hAA;
      $display("drain %0d: data=%0h valid=%0d", i, dataOut, validOut);
      check($sformatf("drain%0d_data", i), 32'(dataOut), 32'(exp_b));
      check($sformatf("drain%0d_valid", i), 32'(validOut), 32'd1);
      tick();
    end
    readyIn = 1'b0;
    check("drain_count", 32'(countOut), 32'd0);
    check("drain_valid", 32'(validOut), 32'd0);

    // Reset in the middle of a pop, with RX level already high at release.
    for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i), 1'b0);
    push_byte(8'hEE, 1'b1);
    check("pre_rst_count", 32'(countOut), 32'd5);
    check("pre_rst_err", 32'(errorOut), 32'd1);
    readyIn = 1'b1; tick();
    check("midpop_count", 32'(countOut), 32'd4);
    check("midpop_data", 32'(dataOut), 32'hB1);
    #2;
    reset = 1'b1; readyIn = 1'b0; rxDataIn = 8'hC7; rxAvailIn = 1'b1;
    #1;
    check("async_count", 32'(countOut), 32'd0);
    check("async_valid", 32'(validOut), 32'd0);
    check("async_err", 32'(errorOut), 32'd0);
    check("async_ovf", 32'(overflowOut), 32'd0);
    check("async_tmo", 32'(timeoutOut), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_count", 32'(countOut), 32'd1);
    check("post_rst_data", 32'(dataOut), 32'hC7);
    tick();
    check("post_rst_once", 32'(countOut), 32'd1);
    rxAvailIn = 1'b0;
    readyIn = 1'b1; tick(); readyIn = 1'b0;
    check("post_rst_empty", 32'(countOut), 32'd0);

    // Idle timeout: rises TMO cycles after the push, falls after the pop.
    rxDataIn = 8'h5A; rxAvailIn = 1'b1; tick(); rxAvailIn = 1'b0;
    check("tmo_push_count", 32'(countOut), 32'd1);
    check("tmo_k0", 32'(timeoutOut), 32'd0);
    for (int k = 1; k <= 25; k++) begin
      tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
      exp_t = (k >= int'(TMO));
`else
      exp_t = 1'b0;
`endif
      $display("idle %0d: timeout=%0d", k, timeoutOut);
      check($sformatf("tmo_k%0d", k), 32'(timeoutOut), 32'(exp_t));
    end
    readyIn = 1'b1; tick(); readyIn = 1'b0;
    check("tmo_pop_count", 32'(countOut), 32'd0);
    check("tmo_after_pop", 32'(timeoutOut), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
